mem_stage_sram: RTL
===================

Name: mem_stage_sram

Overview:
Memory stage placed directly downstream of the execute stage. It consumes the ALU result as the effective address and the second-register value as store data. Each 32-bit word is moved over a 16-bit external SRAM port in two half-word beats, with a programmable number of wait states per beat. The block raises freeze to stall upstream stages during an access, and it contains the MEM/WB pipeline register.

Parameters:
WAIT_CYCLES, 5, cycles each half-word beat is held on the SRAM port (minimum 1)
ADDR_BASE, 1024, byte address mapped to SRAM location 0
SRAM_AW, 18, SRAM half-word address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
mem_read  input  1  load request from EXE/MEM register
mem_write  input  1  store request from EXE/MEM register
wb_en_in  input  1  write-back enable of incoming instruction
dest_in  input  4  destination register index
alu_result  input  32  effective byte address, or ALU result for non-memory instructions
store_data  input  32  data for stores
freeze  output  1  stall request to upstream stages and hazard unit (combinational)
wb_en_out  output  1  registered write-back enable
mem_read_out  output  1  registered; selects mem_data_out in WB
dest_out  output  4  registered destination
alu_result_out  output  32  registered ALU result
mem_data_out  output  32  registered load data
sram_addr  output  SRAM_AW  half-word address
sram_wdata  output  16  half-word write data
sram_rdata  input  16  half-word read data
sram_we  output  1  write strobe, active-high
sram_re  output  1  read strobe, active-high

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: all registered outputs 0; sram_we, sram_re, sram_addr and sram_wdata 0; FSM in IDLE; wait counter 0.
- Address mapping: off = alu_result - ADDR_BASE (32-bit wrap). word = off[SRAM_AW:2], with bits above truncated. off[1:0] is ignored. sram_addr = {word, beat}, where beat 0 is the low half and beat 1 is the high half.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: if mem_read or mem_write, go to LO with counter = 0.
  - LO: drive beat 0 and count to WAIT_CYCLES-1. Then go to HI. For a read, latch sram_rdata into data[15:0] on that final cycle.
  - HI: same as LO for beat 1, latching data[31:16]. Then go to DONE.
  - DONE: go to IDLE unconditionally. The request inputs are still asserted here because upstream was frozen, and must not restart an access.
- Strobes: sram_re (reads) or sram_we (writes) is high for every cycle of LO and HI and low otherwise. sram_wdata = store_data[15:0] in LO and store_data[31:16] in HI. mem_read and mem_write both high is treated as a write.
- freeze = (IDLE and (mem_read or mem_write)) or LO or HI. A memory instruction therefore freezes for 2*WAIT_CYCLES+1 cycles, and freeze is 0 in DONE.
- MEM/WB register:
  - Loads every cycle freeze = 0: inputs in IDLE with no request, or in DONE with mem_data_out = assembled word.
  - While freeze = 1, loads a bubble: wb_en_out = 0, mem_read_out = 0, other fields hold.
- Non-memory instructions: 1-cycle latency, no freeze, SRAM untouched.
- Reset mid-access: abort immediately to IDLE and drop strobes. A partially written word (low half only) is permitted and is not repaired.

Optional Feature:
Macro MEM_READ_CACHE_EN enables a one-entry read cache.
- With the macro: keep valid/word/data of the last completed access. A read whose word matches a valid entry completes from the cache in IDLE: no freeze, no strobes, 1-cycle latency. A completed write loads the entry with store_data. Reset clears valid.
- Without the macro: every read performs the SRAM access; no extra state.

Decomposition:
- Shared package: the FSM state enum (IDLE, LO, HI, DONE), the MEM/WB bundle field widths, and the ADDR_BASE default.
- One sub-module, sram_beat_ctrl, holds the FSM, wait counter and strobe/half-word sequencing. The top level holds address mapping, the MEM/WB register and the optional cache.

Test Plan:
- ALU op (mem_read = mem_write = 0, alu_result = 0x55, wb_en_in = 1, dest_in = 3) -> next cycle alu_result_out = 0x55, wb_en_out = 1, freeze never high.
- Store 0xDEADBEEF to 1032, WAIT_CYCLES = 5 -> sram_addr = 4 with wdata 0xBEEF for 5 cycles, then 5 with 0xDEAD for 5 cycles; freeze high 11 cycles.
- Load from 1032 with the model returning 0xBEEF/0xDEAD -> mem_data_out = 0xDEADBEEF and mem_read_out = 1 after DONE. wb_en_out stays 0 during freeze and is 1 exactly one cycle.
- Back-to-back load then ALU op held by freeze -> the ALU result is registered only after the load completes; no duplicate access.
- rst asserted in HI of a store -> next cycle IDLE, sram_we = 0, all outputs 0, freeze = 0.
- With MEM_READ_CACHE_EN: store then load to the same word -> load completes in 1 cycle, sram_re never asserted, data correct.

Source files
------------

// File: rtl/mem_stage_sram_pkg.sv
// mem_stage_sram_pkg: shared FSM states, MEM/WB bundle and address-map defaults
package mem_stage_sram_pkg;
  localparam int ADDR_BASE_DEF = 1024;
  localparam int DEST_W = 4;
  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  typedef struct packed {
    logic wb_en;
    logic mem_read;
    logic [DEST_W-1:0] dest;
    logic [WORD_W-1:0] alu_result;
    logic [WORD_W-1:0] mem_data;
  } mem_wb_t;
endpackage

// File: rtl/mem_stage_sram_if.sv
// mem_stage_sram_if: 16-bit SRAM port; master is the memory stage, slave is the SRAM
interface mem_stage_sram_if #(parameter int SRAM_AW = 18);
  import mem_stage_sram_pkg::*;
  logic [SRAM_AW-1:0] sram_addr;
  logic [HALF_W-1:0] sram_wdata;
  logic [HALF_W-1:0] sram_rdata;
  logic sram_we;
  logic sram_re;
  modport master (output sram_addr, sram_wdata, sram_we, sram_re, input sram_rdata);
  modport slave (input sram_addr, sram_wdata, sram_we, sram_re, output sram_rdata);
endinterface

// File: rtl/mem_stage_sram_sram_beat_ctrl.sv
// sram_beat_ctrl: two half-word beats per word, each held WAIT_CYCLES cycles
module sram_beat_ctrl
  import mem_stage_sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_write,
  input  logic [WORD_W-1:0] store_data,
  input  logic [HALF_W-1:0] rdata,
  output logic              freeze,
  output logic              busy,
  output logic              beat,
  output logic              we,
  output logic              re,
  output logic              done,
  output logic [HALF_W-1:0] wdata,
  output logic [WORD_W-1:0] data
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      data <= '0;
    end else begin
      state <= state_n;
      cnt <= busy && !last ? cnt + 1'b1 : '0;
      if (re && last && !beat) data[HALF_W-1:0] <= rdata;
      if (re && last && beat) data[WORD_W-1:HALF_W] <= rdata;
    end
  end
  // DONE never restarts: the request is still held there by the frozen upstream
  always_comb
    state_n = state == IDLE ? (start ? LO : IDLE)
            : state == LO   ? (last ? HI : LO)
            : state == HI   ? (last ? DONE : HI) : IDLE;
  always_comb begin
    busy = state == LO || state == HI;
    beat = state == HI;
    done = state == DONE;
    last = cnt == LAST;
    we = busy && is_write;
    re = busy && !is_write;
    wdata = we ? (beat ? store_data[WORD_W-1:HALF_W] : store_data[HALF_W-1:0]) : '0;
    freeze = (state == IDLE && start) || busy;
  end
endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: memory stage over a 16-bit SRAM with MEM/WB register.
// Define MEM_READ_CACHE_EN to add a one-entry read cache.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,
  parameter int ADDR_BASE = ADDR_BASE_DEF,
  parameter int SRAM_AW = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              wb_en_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [WORD_W-1:0] alu_result,
  input  logic [WORD_W-1:0] store_data,
  output logic              freeze,
  output logic              wb_en_out,
  output logic              mem_read_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [WORD_W-1:0] alu_result_out,
  output logic [WORD_W-1:0] mem_data_out,
  mem_stage_sram_if.master  sram
);
  logic [WORD_W-1:0] off, rd_data, hit_data;
  logic [SRAM_AW-2:0] word;
  logic start, hit, busy, beat, done;
  mem_wb_t mw, mw_n;
  assign off = alu_result - WORD_W'(ADDR_BASE);
  assign word = (SRAM_AW-1)'(off >> 2);
  assign start = (mem_read || mem_write) && !hit;
  assign sram.sram_addr = busy ? {word, beat} : '0;
  sram_beat_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .start(start),
    .is_write(mem_write),
    .store_data(store_data),
    .rdata(sram.sram_rdata),
    .freeze(freeze),
    .busy(busy),
    .beat(beat),
    .we(sram.sram_we),
    .re(sram.sram_re),
    .done(done),
    .wdata(sram.sram_wdata),
    .data(rd_data)
  );
`ifdef MEM_READ_CACHE_EN
  logic c_valid;
  logic [SRAM_AW-2:0] c_word;
  logic [WORD_W-1:0] c_data;
  assign hit = mem_read && !mem_write && c_valid && c_word == word;
  assign hit_data = c_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_word <= '0;
      c_data <= '0;
    end else if (done) begin
      c_valid <= 1'b1;
      c_word <= word;
      c_data <= mem_write ? store_data : rd_data;
    end
  end
`else
  assign hit = 1'b0;
  assign hit_data = '0;
`endif
  // frozen cycles insert a bubble and keep the data fields
  always_comb
    mw_n = freeze ? mem_wb_t'{wb_en: 1'b0, mem_read: 1'b0, dest: mw.dest,
                              alu_result: mw.alu_result, mem_data: mw.mem_data}
                  : mem_wb_t'{wb_en: wb_en_in, mem_read: mem_read, dest: dest_in, alu_result: alu_result,
                              mem_data: done ? rd_data : hit ? hit_data : mw.mem_data};
  always_ff @(posedge clk) begin
    if (rst) mw <= '0;
    else mw <= mw_n;
  end
  assign wb_en_out = mw.wb_en;
  assign mem_read_out = mw.mem_read;
  assign dest_out = mw.dest;
  assign alu_result_out = mw.alu_result;
  assign mem_data_out = mw.mem_data;
endmodule
